// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared source tag and default sizing for the register-file write-port arbiter
package wb_pkg;

   localparam int WB_REG_WIDTH    = 32;
   localparam int WB_REG_COUNT    = 32;
   localparam int WB_STARVE_LIMIT = 8;

   typedef enum logic [1:0] {
      WB_SRC_NONE,
      WB_SRC_PIPE,
      WB_SRC_MDU
   } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - pipeline, MDU and register-file write-port signals of the arbiter
interface wb_port_arbiter_if
   import wb_pkg::*;
#(
   parameter int REG_WIDTH = WB_REG_WIDTH,
   parameter int REG_COUNT = WB_REG_COUNT
) ();
   localparam int AW = $clog2(REG_COUNT);

   logic                 pipe_we;
   logic [AW-1:0]        pipe_rd;
   logic [REG_WIDTH-1:0] pipe_data;
   logic                 pipe_stall;
   logic                 mdu_issue;
   logic [AW-1:0]        mdu_issue_rd;
   logic                 mdu_valid;
   logic                 mdu_ready;
   logic [AW-1:0]        mdu_rd;
   logic [REG_WIDTH-1:0] mdu_data;
   logic [REG_COUNT-1:0] pending;
   logic [AW-1:0]        rd;
   logic                 RegWrite;
   logic [REG_WIDTH-1:0] BusW;

   // master: writeback/MDU/register-file side; slave: the arbiter itself
   modport master (
      output pipe_we, pipe_rd, pipe_data, mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_data,
      input  pipe_stall, mdu_ready, pending, rd, RegWrite, BusW
   );

   modport slave (
      input  pipe_we, pipe_rd, pipe_data, mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_data,
      output pipe_stall, mdu_ready, pending, rd, RegWrite, BusW
   );

endinterface

// File: rtl/wb_pending_scoreboard.sv
// rtl/wb_pending_scoreboard.sv - outstanding-MDU-write bit vector; set beats clear, bit 0 hard-wired low
module wb_pending_scoreboard
   import wb_pkg::*;
#(
   parameter int REG_COUNT = WB_REG_COUNT,
   localparam int AW = $clog2(REG_COUNT)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 set_en,
   input  logic [AW-1:0]        set_idx,
   input  logic                 clr_en,
   input  logic [AW-1:0]        clr_idx,
   output logic [REG_COUNT-1:0] pending
);
   logic [REG_COUNT-1:0] set_mask;
   logic [REG_COUNT-1:0] clr_mask;
   logic [REG_COUNT-1:0] pend_d;
   logic [REG_COUNT-1:0] pend_q;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[set_idx] = 1'b1;
      if (clr_en) clr_mask[clr_idx] = 1'b1;
      pend_d = (pend_q & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pend_q <= '0;
      else       pend_q <= {pend_d[REG_COUNT-1:1], 1'b0};
   end

   assign pending = pend_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - merges pipeline writeback and MDU results onto one register-file write port
// WB_STARVE_GUARD_EN enables the MDU starvation counter and the registered pipe_stall slot.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int REG_WIDTH    = WB_REG_WIDTH,
   parameter int REG_COUNT    = WB_REG_COUNT,
   parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
   input logic              clk,
   input logic              reset,
   wb_port_arbiter_if.slave bus
);
   localparam int AW = $clog2(REG_COUNT);

   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
   end

   wb_src_e              src_q, src_d;
   logic [AW-1:0]        rd_q, rd_d;
   logic [REG_WIDTH-1:0] busw_q, busw_d;
   logic                 regwrite_q, regwrite_d;
   logic                 stall_q;
   logic                 mdu_ready_w;
   logic                 pipe_fire, mdu_fire;
   logic                 clr_en;

`ifdef WB_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] starve_q, starve_d;
   logic          stall_d;

   // counter drops to 0 on any transfer or idle MDU; reaching the limit buys one stalled cycle
   always_comb begin
      starve_d = '0;
      if (bus.mdu_valid && !mdu_ready_w)
         starve_d = (starve_q == CW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
      stall_d = (starve_d == CW'(STARVE_LIMIT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   assign mdu_ready_w = !bus.pipe_we || stall_q;
`else
   assign stall_q     = 1'b0;
   assign mdu_ready_w = !bus.pipe_we;
`endif

   assign pipe_fire = bus.pipe_we && !stall_q;
   assign mdu_fire  = bus.mdu_valid && mdu_ready_w;

   always_comb begin
      src_d      = WB_SRC_NONE;
      rd_d       = rd_q;
      busw_d     = busw_q;
      regwrite_d = 1'b0;
      if (pipe_fire) begin
         src_d      = WB_SRC_PIPE;
         rd_d       = bus.pipe_rd;
         busw_d     = bus.pipe_data;
         regwrite_d = (bus.pipe_rd != '0);
      end else if (mdu_fire) begin
         src_d      = WB_SRC_MDU;
         rd_d       = bus.mdu_rd;
         busw_d     = bus.mdu_data;
         regwrite_d = (bus.mdu_rd != '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q      <= WB_SRC_NONE;
         rd_q       <= '0;
         busw_q     <= '0;
         regwrite_q <= 1'b0;
      end else begin
         src_q      <= src_d;
         rd_q       <= rd_d;
         busw_q     <= busw_d;
         regwrite_q <= regwrite_d;
      end
   end

   // the register file consumes the MDU write at the edge ending the RegWrite cycle
   assign clr_en = (src_q == WB_SRC_MDU) && regwrite_q;

   wb_pending_scoreboard #(.REG_COUNT(REG_COUNT)) u_scoreboard (
      .clk     (clk),
      .reset   (reset),
      .set_en  (bus.mdu_issue && (bus.mdu_issue_rd != '0)),
      .set_idx (bus.mdu_issue_rd),
      .clr_en  (clr_en),
      .clr_idx (rd_q),
      .pending (bus.pending)
   );

   assign bus.mdu_ready  = mdu_ready_w;
   assign bus.pipe_stall = stall_q;
   assign bus.rd         = rd_q;
   assign bus.BusW       = busw_q;
   assign bus.RegWrite   = regwrite_q;

`ifndef SYNTHESIS
   a_no_write_in_stall: assert property (@(posedge clk) disable iff (reset)
      !(bus.pipe_we && stall_q));

   a_no_double_issue: assert property (@(posedge clk) disable iff (reset)
      !(bus.mdu_issue && (bus.mdu_issue_rd != '0) && bus.pending[bus.mdu_issue_rd]
        && !(clr_en && (rd_q == bus.mdu_issue_rd))));
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   wb_port_arbiter_if #(.REG_WIDTH(32), .REG_COUNT(32)) bus ();

   wb_port_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.pipe_we      = 1'b0;
      bus.pipe_rd      = '0;
      bus.pipe_data    = '0;
      bus.mdu_issue    = 1'b0;
      bus.mdu_issue_rd = '0;
      bus.mdu_valid    = 1'b0;
      bus.mdu_rd       = '0;
      bus.mdu_data     = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
      tests_run++; if (bus.rd !== 5'd0) begin tests_failed++; $display("FAIL reset_rd: got %0d want 0", bus.rd); end
      tests_run++; if (bus.BusW !== 32'd0) begin tests_failed++; $display("FAIL reset_busw: got %h want 0", bus.BusW); end
      tests_run++; if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite); end
      tests_run++; if (bus.pipe_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", bus.pipe_stall); end
      tests_run++; if (bus.pending !== 32'd0) begin tests_failed++; $display("FAIL reset_pending: got %h want 0", bus.pending); end
      tests_run++; if (bus.mdu_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_mdu_ready: got %b want 1", bus.mdu_ready); end
   endtask

   task automatic test_pipe_write();
      bus.pipe_we = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
      #1;
      tests_run++; if (bus.mdu_ready !== 1'b0) begin tests_failed++; $display("FAIL pipe_prio_ready: got %b want 0", bus.mdu_ready); end
      cyc();
      bus.pipe_we = 1'b0;
      tests_run++; if (bus.rd !== 5'd5) begin tests_failed++; $display("FAIL pipe_rd: got %0d want 5", bus.rd); end
      tests_run++; if (bus.BusW !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL pipe_busw: got %h want deadbeef", bus.BusW); end
      tests_run++; if (bus.RegWrite !== 1'b1) begin tests_failed++; $display("FAIL pipe_regwrite: got %b want 1", bus.RegWrite); end
      cyc();
      tests_run++; if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("FAIL pipe_idle_regwrite: got %b want 0", bus.RegWrite); end
      tests_run++; if (bus.rd !== 5'd5 || bus.BusW !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL pipe_hold: got rd=%0d busw=%h want rd=5 busw=deadbeef", bus.rd, bus.BusW); end
   endtask

   task automatic test_mdu_pending();
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd7;
      cyc();
      bus.mdu_issue = 1'b0;
      tests_run++; if (bus.pending !== 32'h80) begin tests_failed++; $display("FAIL mdu_issue_set: got %h want 00000080", bus.pending); end
      cyc();
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'd42;
      #1;
      tests_run++; if (bus.mdu_ready !== 1'b1) begin tests_failed++; $display("FAIL mdu_ready_idle: got %b want 1", bus.mdu_ready); end
      cyc();
      bus.mdu_valid = 1'b0;
      tests_run++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd7 || bus.BusW !== 32'd42) begin tests_failed++; $display("FAIL mdu_write: got we=%b rd=%0d busw=%0d want we=1 rd=7 busw=42", bus.RegWrite, bus.rd, bus.BusW); end
      tests_run++; if (bus.pending !== 32'h80) begin tests_failed++; $display("FAIL mdu_pending_held: got %h want 00000080", bus.pending); end
      // reissue to x7 on the edge that retires the previous result
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd7;
      cyc();
      bus.mdu_issue = 1'b0;
      tests_run++; if (bus.pending !== 32'h80) begin tests_failed++; $display("FAIL reissue_set_wins: got %h want 00000080", bus.pending); end
      tests_run++; if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("FAIL reissue_regwrite: got %b want 0", bus.RegWrite); end
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'd43;
      cyc();
      bus.mdu_valid = 1'b0;
      tests_run++; if (bus.RegWrite !== 1'b1 || bus.BusW !== 32'd43) begin tests_failed++; $display("FAIL mdu_write2: got we=%b busw=%0d want we=1 busw=43", bus.RegWrite, bus.BusW); end
      tests_run++; if (bus.pending !== 32'h80) begin tests_failed++; $display("FAIL mdu_pending_held2: got %h want 00000080", bus.pending); end
      cyc();
      tests_run++; if (bus.pending !== 32'd0) begin tests_failed++; $display("FAIL mdu_pending_clear: got %h want 0", bus.pending); end
   endtask

   task automatic test_x0();
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd0;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'd99;
      #1;
      tests_run++; if (bus.mdu_ready !== 1'b1) begin tests_failed++; $display("FAIL x0_ready: got %b want 1", bus.mdu_ready); end
      cyc();
      idle_inputs();
      tests_run++; if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("FAIL x0_regwrite: got %b want 0", bus.RegWrite); end
      tests_run++; if (bus.rd !== 5'd0 || bus.BusW !== 32'd99) begin tests_failed++; $display("FAIL x0_port: got rd=%0d busw=%0d want rd=0 busw=99", bus.rd, bus.BusW); end
      tests_run++; if (bus.pending !== 32'd0) begin tests_failed++; $display("FAIL x0_pending: got %h want 0", bus.pending); end
      bus.pipe_we = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'h1234;
      cyc();
      bus.pipe_we = 1'b0;
      tests_run++; if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("FAIL pipe_x0_regwrite: got %b want 0", bus.RegWrite); end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) begin
         bus.pipe_we = 1'b1; bus.pipe_rd = 5'(i); bus.pipe_data = 32'h100 + 32'(i);
         cyc();
         tests_run++;
         if (bus.RegWrite !== 1'b1 || bus.rd !== 5'(i) || bus.BusW !== 32'h100 + 32'(i)) begin
            tests_failed++;
            $display("FAIL b2b_%0d: got we=%b rd=%0d busw=%h want we=1 rd=%0d busw=%h", i, bus.RegWrite, bus.rd, bus.BusW, i, 32'h100 + 32'(i));
         end
      end
      bus.pipe_we = 1'b0;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_data = 32'hABC;
      cyc();
      bus.mdu_valid = 1'b0;
      tests_run++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd12 || bus.BusW !== 32'hABC) begin tests_failed++; $display("FAIL b2b_mdu: got we=%b rd=%0d busw=%h want we=1 rd=12 busw=abc", bus.RegWrite, bus.rd, bus.BusW); end
      cyc();
   endtask

   task automatic test_starvation();
      bus.pipe_we = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_data = 32'h0;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h55;
`ifdef WB_STARVE_GUARD_EN
      for (int i = 0; i < 8; i++) begin
         bus.pipe_data = 32'(i);
         #1;
         tests_run++;
         if (bus.mdu_ready !== 1'b0 || bus.pipe_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL starve_blocked_%0d: got ready=%b stall=%b want ready=0 stall=0", i, bus.mdu_ready, bus.pipe_stall);
         end
         cyc();
      end
      tests_run++; if (bus.pipe_stall !== 1'b1) begin tests_failed++; $display("FAIL starve_stall: got %b want 1", bus.pipe_stall); end
      bus.pipe_we = 1'b0;
      #1;
      tests_run++; if (bus.mdu_ready !== 1'b1) begin tests_failed++; $display("FAIL starve_ready: got %b want 1", bus.mdu_ready); end
      cyc();
      bus.mdu_valid = 1'b0;
      bus.pipe_we = 1'b1;
      tests_run++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd9 || bus.BusW !== 32'h55) begin tests_failed++; $display("FAIL starve_mdu_write: got we=%b rd=%0d busw=%h want we=1 rd=9 busw=55", bus.RegWrite, bus.rd, bus.BusW); end
      tests_run++; if (bus.pipe_stall !== 1'b0) begin tests_failed++; $display("FAIL starve_stall_once: got %b want 0", bus.pipe_stall); end
      cyc();
      bus.pipe_we = 1'b0;
`else
      for (int i = 0; i < 20; i++) begin
         #1;
         tests_run++;
         if (bus.mdu_ready !== 1'b0 || bus.pipe_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL noguard_blocked_%0d: got ready=%b stall=%b want ready=0 stall=0", i, bus.mdu_ready, bus.pipe_stall);
         end
         cyc();
      end
      bus.pipe_we = 1'b0;
      cyc();
      bus.mdu_valid = 1'b0;
      tests_run++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd9 || bus.BusW !== 32'h55) begin tests_failed++; $display("FAIL noguard_mdu_write: got we=%b rd=%0d busw=%h want we=1 rd=9 busw=55", bus.RegWrite, bus.rd, bus.BusW); end
`endif
      cyc();
   endtask

   task automatic test_reset_midflight();
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd3;
      cyc();
      bus.mdu_issue = 1'b0;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_data = 32'd7;
      cyc();
      bus.mdu_valid = 1'b0;
      tests_run++; if (bus.pending !== 32'h8 || bus.RegWrite !== 1'b1) begin tests_failed++; $display("FAIL midflight_pre: got pending=%h we=%b want pending=00000008 we=1", bus.pending, bus.RegWrite); end
      #2;
      reset = 1'b1;
      #1;
      tests_run++; if (bus.pending !== 32'd0) begin tests_failed++; $display("FAIL midflight_pending: got %h want 0", bus.pending); end
      tests_run++; if (bus.RegWrite !== 1'b0 || bus.rd !== 5'd0) begin tests_failed++; $display("FAIL midflight_port: got we=%b rd=%0d want we=0 rd=0", bus.RegWrite, bus.rd); end
      cyc();
      reset = 1'b0;
      cyc();
      tests_run++; if (bus.pending !== 32'd0 || bus.RegWrite !== 1'b0) begin tests_failed++; $display("FAIL midflight_post: got pending=%h we=%b want 0 0", bus.pending, bus.RegWrite); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_pipe_write();
      test_mdu_pending();
      test_x0();
      test_back_to_back();
      test_starvation();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-side initiator for the core's single-write-port register file: merges the in-order pipeline writeback stream and the multi-cycle multiply/divide unit (MDU) result stream into one registered `rd`/`RegWrite`/`BusW` write port. It keeps a pending-write scoreboard of registers awaiting MDU results so decode can stall on RAW hazards. An optional starvation guard forces an MDU slot when the pipeline monopolises the port. It sits between the writeback stage and the register file.

## Interface
- `REG_WIDTH`, 32, data width
- `REG_COUNT`, 32, architectural registers; index width `AW = $clog2(REG_COUNT)`
- `STARVE_LIMIT`, 8, consecutive blocked MDU cycles before a slot is forced (≥1)

- `clk` input 1: the block's only clock
- `reset` input 1: asynchronous, active-high
- `pipe_we` input 1: pipeline writeback valid (no backpressure)
- `pipe_rd` input AW: pipeline destination
- `pipe_data` input REG_WIDTH: pipeline result
- `pipe_stall` output 1: registered; pipeline must hold writeback (`pipe_we`=0) this cycle
- `mdu_issue` input 1: pulse; MDU op dispatched
- `mdu_issue_rd` input AW: its destination
- `mdu_valid` input 1: MDU result available
- `mdu_ready` output 1: result accepted this cycle
- `mdu_rd` input AW, `mdu_data` input REG_WIDTH: MDU result
- `pending` output REG_COUNT: bit i set = MDU write to xi outstanding
- `rd` output AW, `RegWrite` output 1, `BusW` output REG_WIDTH: register-file write port

## Operation
- Pipeline has fixed priority: `mdu_ready = !pipe_we || pipe_stall` (combinational). MDU transfer on `mdu_valid && mdu_ready`.
- Granted source is registered into `rd`/`BusW`; `RegWrite` = granted && destination ≠ 0. x0 writes: handshake completes, `RegWrite` stays 0.
- No grant: `RegWrite`=0; `rd`/`BusW` hold their previous values.
- Scoreboard: `mdu_issue` with `mdu_issue_rd`≠0 sets its bit. Bit clears at the edge where the MDU-sourced `RegWrite` is consumed by the register file (cycle after `RegWrite`=1), so `pending` never drops before data is readable. Same-edge set and clear of the same bit: set wins. Bit 0 is always 0.
- Issuing to an already-pending rd is a protocol violation. Asserting `pipe_we` while `pipe_stall`=1 is also a violation. Both are flagged by simulation assertions.

## Timing
- Reset: `rd`=0, `BusW`=0, `RegWrite`=0, `pipe_stall`=0, `pending`=0, starvation counter=0. `mdu_ready` follows its combinational equation.
- Latency: accepted at edge N → `RegWrite`=1 during cycle N+1 → register file written at edge N+1 → MDU pending bit clears at edge N+1 (visible cycle N+2).
- Throughput: one write per cycle.
- Starvation counter increments each cycle `mdu_valid && !mdu_ready` holds. It resets to 0 on any MDU transfer or when `mdu_valid`=0. It saturates at `STARVE_LIMIT`.
- When the counter reaches `STARVE_LIMIT`, `pipe_stall` is 1 for exactly the next cycle. That cycle the MDU is granted, then the counter clears.
- Reset mid-operation: outstanding pending bits and any in-flight write are discarded. The MDU is reset by the same `reset`.

## Configuration
- `WB_STARVE_GUARD_EN` defined: starvation counter and `pipe_stall` logic as above.
- Not defined: no counter; `pipe_stall` is tied 0; `mdu_ready = !pipe_we`. The MDU waits for idle pipeline slots indefinitely.

## Structure
- Package `wb_pkg`:
  - `wb_src_e` enum {`WB_SRC_NONE`, `WB_SRC_PIPE`, `WB_SRC_MDU`}
  - default width constants
  - the `STARVE_LIMIT` default
- The registered source tag (`wb_src_e`) drives the scoreboard clear.
- Sub-module `wb_pending_scoreboard`: set/clear bit vector with set-priority and hard-wired bit 0.

## Test plan
- Reset, then idle: all outputs 0; `mdu_ready`=1.
- `pipe_we`=1, `pipe_rd`=5, `pipe_data`=0xDEADBEEF → next cycle `rd`=5, `BusW`=0xDEADBEEF, `RegWrite`=1.
- `mdu_issue` rd=7; later `mdu_valid` rd=7 data=42 with pipe idle → `pending[7]`=1 until the cycle after `RegWrite`=1 with `rd`=7; the same-edge reissue to 7 keeps it set.
- `pipe_we` and `mdu_valid` both held high, guard enabled, `STARVE_LIMIT`=8 → `mdu_ready`=0 for 8 cycles, then `pipe_stall`=1 for one cycle, MDU accepted, and its write appears the next cycle.
- MDU result to x0 → handshake completes, `RegWrite` stays 0, `pending` stays 0.
- Reset asserted while `pending[3]`=1 and an MDU write is in flight → `pending`=0 and `RegWrite`=0 immediately, asynchronously.
